wb_mem_cache: RTL and testbench

WB_MEM_CACHE -- requirements
Module: wb_mem_cache

---
 rtl/wb_mem_cache_pkg.sv | 31 +++
 rtl/wb_mem_cache_if.sv | 32 +++
 rtl/wb_cache_array.sv | 58 +++++
 rtl/wb_mem_cache.sv | 143 ++++++++++++++
 tb/tb_wb_mem_cache.sv | 310 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_mem_cache_pkg.sv
// Shared types and defaults for the write-through, direct-mapped word cache
// that sits in front of a slow SPI SRAM.
package wb_mem_cache_pkg;

  localparam int         ENTRIES_DEF = 8;
  localparam int         ADR_W_DEF   = 14;
  localparam logic [3:0] SEL_ALL     = 4'hF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    WRITE = 2'd2,
    ACK   = 2'd3
  } state_e;

  function automatic logic [31:0] byte_merge(input logic [31:0] old_dat,
                                             input logic [31:0] new_dat,
                                             input logic [3:0]  sel);
    logic [31:0] res;
    res = old_dat;
    for (int b = 0; b < 4; b++) begin
      if (sel[b]) begin
        res[8*b +: 8] = new_dat[8*b +: 8];
      end else begin
        res[8*b +: 8] = old_dat[8*b +: 8];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/wb_mem_cache_if.sv
// CPU-side Wishbone and SRAM-side bus signals of the cache; the slave
// modport is the cache's view, the master modport the surrounding system's.
interface wb_mem_cache_if
  import wb_mem_cache_pkg::*;
#(
  parameter int ADR_W = ADR_W_DEF
);
  logic [ADR_W-1:0] i_wb_adr;
  logic [31:0]      i_wb_dat;
  logic [3:0]       i_wb_sel;
  logic             i_wb_we;
  logic             i_wb_stb;
  logic [31:0]      o_wb_rdt;
  logic             o_wb_ack;
  logic             o_mem_cyc;
  logic [ADR_W-1:0] o_mem_adr;
  logic             o_mem_we;
  logic [31:0]      o_mem_dat;
  logic [3:0]       o_mem_sel;
  logic [31:0]      i_mem_rdt;
  logic             i_mem_ack;

  modport slave (
    input  i_wb_adr, i_wb_dat, i_wb_sel, i_wb_we, i_wb_stb, i_mem_rdt, i_mem_ack,
    output o_wb_rdt, o_wb_ack, o_mem_cyc, o_mem_adr, o_mem_we, o_mem_dat, o_mem_sel
  );

  modport master (
    output i_wb_adr, i_wb_dat, i_wb_sel, i_wb_we, i_wb_stb, i_mem_rdt, i_mem_ack,
    input  o_wb_rdt, o_wb_ack, o_mem_cyc, o_mem_adr, o_mem_we, o_mem_dat, o_mem_sel
  );
endinterface

// File: rtl/wb_cache_array.sv
// Line storage: valid/tag/data per index, combinational hit compare,
// whole-line fill and byte-merge update of a hitting line.
module wb_cache_array
  import wb_mem_cache_pkg::*;
#(
  parameter int ENTRIES = ENTRIES_DEF,
  parameter int ADR_W   = ADR_W_DEF
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_flush,
  input  logic [ADR_W-1:0] i_adr,
  output logic             o_hit,
  output logic [31:0]      o_dat,
  input  logic             i_fill,
  input  logic [31:0]      i_fill_dat,
  input  logic             i_merge,
  input  logic [3:0]       i_sel,
  input  logic [31:0]      i_wr_dat
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = ADR_W - IDX_W;

  logic [ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]   tag_q  [ENTRIES];
  logic [31:0]        data_q [ENTRIES];
  logic [IDX_W-1:0]   idx_s;
  logic [TAG_W-1:0]   tag_s;

  assign idx_s = i_adr[IDX_W-1:0];
  assign tag_s = i_adr[ADR_W-1:IDX_W];
  assign o_hit = valid_q[idx_s] && (tag_q[idx_s] == tag_s);
  assign o_dat = data_q[idx_s];

  // Valid bits: flush beats a coincident fill so the filled line stays invalid.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      valid_q <= '0;
    end else if (i_flush) begin
      valid_q <= '0;
    end else if (i_fill) begin
      valid_q[idx_s] <= 1'b1;
    end else begin
      valid_q <= valid_q;
    end
  end

  // Tag and data need no reset; they are qualified by the valid bit.
  always_ff @(posedge i_clk) begin
    if (i_fill) begin
      tag_q[idx_s]  <= tag_s;
      data_q[idx_s] <= i_fill_dat;
    end else if (i_merge && o_hit) begin
      data_q[idx_s] <= byte_merge(data_q[idx_s], i_wr_dat, i_sel);
    end
  end

endmodule

// File: rtl/wb_mem_cache.sv
// Write-through, read-allocate, direct-mapped one-word cache between a
// Wishbone CPU port and a slow SPI-SRAM controller.
module wb_mem_cache
  import wb_mem_cache_pkg::*;
#(
  parameter int ENTRIES = ENTRIES_DEF,
  parameter int ADR_W   = ADR_W_DEF
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic           i_flush,
  wb_mem_cache_if.slave  bus
);
  state_e           state_q, state_d;
  logic             ack_q, ack_d;
  logic             cyc_q, cyc_d;
  logic             we_q, we_d;
  logic [ADR_W-1:0] adr_q, adr_d;
  logic [31:0]      dat_q, dat_d;
  logic [3:0]       sel_q, sel_d;
  logic [31:0]      rdt_q, rdt_d;
  logic             hit_s;
  logic [31:0]      line_dat_s;
  logic             fill_s;
  logic             merge_s;

  // The CPU holds its address until ack, so it doubles as the fill/merge index.
  wb_cache_array #(
    .ENTRIES (ENTRIES),
    .ADR_W   (ADR_W)
  ) u_array (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_flush    (i_flush),
    .i_adr      (bus.i_wb_adr),
    .o_hit      (hit_s),
    .o_dat      (line_dat_s),
    .i_fill     (fill_s),
    .i_fill_dat (bus.i_mem_rdt),
    .i_merge    (merge_s),
    .i_sel      (bus.i_wb_sel),
    .i_wr_dat   (bus.i_wb_dat)
  );

  always_comb begin
    state_d = state_q;
    ack_d   = 1'b0;
    cyc_d   = cyc_q;
    we_d    = we_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    sel_d   = sel_q;
    rdt_d   = rdt_q;
    fill_s  = 1'b0;
    merge_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.i_wb_stb && bus.i_wb_we) begin
          state_d = WRITE;
          cyc_d   = 1'b1;
          we_d    = 1'b1;
          adr_d   = bus.i_wb_adr;
          dat_d   = bus.i_wb_dat;
          sel_d   = bus.i_wb_sel;
        end else if (bus.i_wb_stb && hit_s) begin
          state_d = ACK;
          ack_d   = 1'b1;
          rdt_d   = line_dat_s;
        end else if (bus.i_wb_stb) begin
          state_d = FILL;
          cyc_d   = 1'b1;
          we_d    = 1'b0;
          adr_d   = bus.i_wb_adr;
          sel_d   = SEL_ALL;
        end else begin
          state_d = IDLE;
        end
      end
      FILL: begin
        if (bus.i_mem_ack) begin
          fill_s  = 1'b1;
          rdt_d   = bus.i_mem_rdt;
          cyc_d   = 1'b0;
          ack_d   = 1'b1;
          state_d = ACK;
        end else begin
          state_d = FILL;
        end
      end
      WRITE: begin
        if (bus.i_mem_ack) begin
          // A coincident flush suppresses the merge; the line is invalid anyway.
          merge_s = !i_flush;
          cyc_d   = 1'b0;
          we_d    = 1'b0;
          ack_d   = 1'b1;
          state_d = ACK;
        end else begin
          state_d = WRITE;
        end
      end
      ACK: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cyc_d   = 1'b0;
        we_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      ack_q   <= 1'b0;
      cyc_q   <= 1'b0;
      we_q    <= 1'b0;
      adr_q   <= '0;
      dat_q   <= 32'h0000_0000;
      sel_q   <= 4'h0;
      rdt_q   <= 32'h0000_0000;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      cyc_q   <= cyc_d;
      we_q    <= we_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      sel_q   <= sel_d;
      rdt_q   <= rdt_d;
    end
  end

  assign bus.o_wb_ack  = ack_q;
  assign bus.o_wb_rdt  = rdt_q;
  assign bus.o_mem_cyc = cyc_q;
  assign bus.o_mem_we  = we_q;
  assign bus.o_mem_adr = adr_q;
  assign bus.o_mem_dat = dat_q;
  assign bus.o_mem_sel = sel_q;

endmodule

// File: tb/tb_wb_mem_cache.sv
// Bench for wb_mem_cache: an SRAM responder with programmable latency, a read
// scoreboard queue, and one task per scenario.
module tb_wb_mem_cache;
  import wb_mem_cache_pkg::*;

  localparam int ADR_W = ADR_W_DEF;

  logic i_clk = 1'b0;
  logic i_rst = 1'b1;
  logic i_flush;
  logic flush_tb = 1'b0;
  logic flush_resp = 1'b0;

  assign i_flush = flush_tb | flush_resp;

  wb_mem_cache_if #(.ADR_W(ADR_W)) bus ();

  wb_mem_cache #(.ENTRIES(ENTRIES_DEF), .ADR_W(ADR_W)) dut (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_flush (i_flush),
    .bus     (bus)
  );

  always #5 i_clk = ~i_clk;

  int checks = 0;
  int errors = 0;
  int mem_txn = 0;
  int cyc_cnt = 0;
  int mem_lat = 5;
  logic mem_hold = 1'b0;
  logic flush_on_ack = 1'b0;
  logic [31:0] mem_data = 32'h0000_0000;
  logic [ADR_W-1:0] last_adr;
  logic last_we;
  logic [31:0] last_dat;
  logic [3:0] last_sel;
  logic [31:0] exp_q [$];

  // SRAM model: acks mem_lat cycles after o_mem_cyc, optionally with a flush pulse
  initial begin
    int wait_cnt;
    wait_cnt = 0;
    bus.i_mem_ack = 1'b0;
    bus.i_mem_rdt = 32'h0000_0000;
    forever begin
      @(negedge i_clk);
      if (bus.o_mem_cyc) cyc_cnt++;
      if (bus.i_mem_ack) begin
        bus.i_mem_ack = 1'b0;
        flush_resp = 1'b0;
      end else if (bus.o_mem_cyc && !mem_hold) begin
        if (wait_cnt >= mem_lat - 1) begin
          bus.i_mem_ack = 1'b1;
          bus.i_mem_rdt = mem_data;
          flush_resp = flush_on_ack;
          last_adr = bus.o_mem_adr;
          last_we = bus.o_mem_we;
          last_dat = bus.o_mem_dat;
          last_sel = bus.o_mem_sel;
          mem_txn++;
          wait_cnt = 0;
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  task automatic do_read(input logic [ADR_W-1:0] adr, input logic [31:0] exp,
                         input bit exp_hit, input string name);
    int n, txn0, cyc0;
    bit got;
    logic [31:0] e;
    exp_q.push_back(exp);
    txn0 = mem_txn;
    cyc0 = cyc_cnt;
    bus.i_wb_adr = adr;
    bus.i_wb_we = 1'b0;
    bus.i_wb_sel = 4'hF;
    bus.i_wb_dat = 32'h0000_0000;
    bus.i_wb_stb = 1'b1;
    got = 1'b0;
    n = 0;
    while (!got && n < 60) begin
      @(negedge i_clk);
      n++;
      if (bus.o_wb_ack) got = 1'b1;
    end
    bus.i_wb_stb = 1'b0;
    e = exp_q.pop_front();
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL %s ack_timeout got no ack want ack", name);
    end else begin
      checks++;
      if (bus.o_wb_rdt !== e) begin
        errors++;
        $display("FAIL %s rdt got %h want %h", name, bus.o_wb_rdt, e);
      end
      checks++;
      if (bus.o_mem_cyc !== 1'b0) begin
        errors++;
        $display("FAIL %s cyc_at_ack got %b want 0", name, bus.o_mem_cyc);
      end
      if (exp_hit) begin
        checks++;
        if (n !== 1 || cyc_cnt !== cyc0) begin
          errors++;
          $display("FAIL %s hit got latency %0d cyc %0d want 1 and 0", name, n, cyc_cnt - cyc0);
        end
      end else begin
        checks++;
        if ((mem_txn - txn0) !== 1 || last_we !== 1'b0 || last_adr !== adr || last_sel !== 4'hF) begin
          errors++;
          $display("FAIL %s miss got txn %0d we %b adr %h sel %h want 1 0 %h f",
                   name, mem_txn - txn0, last_we, last_adr, last_sel, adr);
        end
      end
    end
    @(negedge i_clk);
    checks++;
    if (bus.o_wb_ack !== 1'b0) begin
      errors++;
      $display("FAIL %s ack_width got %b want 0", name, bus.o_wb_ack);
    end
  endtask

  task automatic do_write(input logic [ADR_W-1:0] adr, input logic [31:0] dat,
                          input logic [3:0] sel, input string name);
    int n, txn0;
    bit got;
    txn0 = mem_txn;
    bus.i_wb_adr = adr;
    bus.i_wb_we = 1'b1;
    bus.i_wb_sel = sel;
    bus.i_wb_dat = dat;
    bus.i_wb_stb = 1'b1;
    got = 1'b0;
    n = 0;
    while (!got && n < 60) begin
      @(negedge i_clk);
      n++;
      if (bus.o_wb_ack) got = 1'b1;
    end
    bus.i_wb_stb = 1'b0;
    bus.i_wb_we = 1'b0;
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL %s ack_timeout got no ack want ack", name);
    end else begin
      checks++;
      if ((mem_txn - txn0) !== 1 || last_we !== 1'b1 || last_adr !== adr ||
          last_dat !== dat || last_sel !== sel) begin
        errors++;
        $display("FAIL %s sram_write got txn %0d we %b adr %h dat %h sel %h want 1 1 %h %h %h",
                 name, mem_txn - txn0, last_we, last_adr, last_dat, last_sel, adr, dat, sel);
      end
      checks++;
      if (bus.o_mem_cyc !== 1'b0) begin
        errors++;
        $display("FAIL %s cyc_at_ack got %b want 0", name, bus.o_mem_cyc);
      end
    end
    @(negedge i_clk);
    checks++;
    if (bus.o_wb_ack !== 1'b0) begin
      errors++;
      $display("FAIL %s ack_width got %b want 0", name, bus.o_wb_ack);
    end
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    bus.i_wb_stb = 1'b0;
    bus.i_wb_we = 1'b0;
    bus.i_wb_adr = '0;
    bus.i_wb_dat = 32'h0000_0000;
    bus.i_wb_sel = 4'h0;
    repeat (3) @(negedge i_clk);
    checks++;
    if (bus.o_wb_ack !== 1'b0 || bus.o_mem_cyc !== 1'b0 || bus.o_mem_we !== 1'b0 ||
        bus.o_wb_rdt !== 32'h0000_0000) begin
      errors++;
      $display("FAIL reset got ack %b cyc %b we %b rdt %h want 0 0 0 0",
               bus.o_wb_ack, bus.o_mem_cyc, bus.o_mem_we, bus.o_wb_rdt);
    end
    i_rst = 1'b0;
    @(negedge i_clk);
  endtask

  task automatic test_read_miss_hit();
    mem_lat = 5;
    mem_data = 32'hDEAD_BEEF;
    do_read(14'h0010, 32'hDEAD_BEEF, 1'b0, "rd_miss_0010");
    mem_data = 32'h1111_2222;
    do_read(14'h0010, 32'hDEAD_BEEF, 1'b1, "rd_hit_0010");
  endtask

  task automatic test_write_merge();
    mem_lat = 3;
    do_write(14'h0010, 32'h0000_5500, 4'b0010, "wr_hit_0010");
    do_read(14'h0010, 32'hDEAD_55EF, 1'b1, "rd_merged_0010");
  endtask

  task automatic test_index_wrap();
    mem_data = 32'h1818_1818;
    do_read(14'h0018, 32'h1818_1818, 1'b0, "rd_miss_0018");
    do_read(14'h0018, 32'h1818_1818, 1'b1, "rd_hit_0018");
    mem_data = 32'h1010_1010;
    do_read(14'h0010, 32'h1010_1010, 1'b0, "rd_evicted_0010");
  endtask

  task automatic test_write_miss();
    do_write(14'h0020, 32'hA5A5_5A5A, 4'hF, "wr_miss_0020");
    mem_data = 32'h2020_2020;
    do_read(14'h0020, 32'h2020_2020, 1'b0, "rd_noalloc_0020");
  endtask

  task automatic test_flush();
    flush_on_ack = 1'b1;
    mem_data = 32'hCAFE_0030;
    do_read(14'h0030, 32'hCAFE_0030, 1'b0, "rd_flush_fill_0030");
    flush_on_ack = 1'b0;
    mem_data = 32'h0BAD_0030;
    do_read(14'h0030, 32'h0BAD_0030, 1'b0, "rd_after_flush_0030");
    mem_data = 32'h1111_1111;
    do_read(14'h0011, 32'h1111_1111, 1'b0, "rd_miss_0011");
    do_read(14'h0011, 32'h1111_1111, 1'b1, "rd_hit_0011");
    flush_tb = 1'b1;
    @(negedge i_clk);
    flush_tb = 1'b0;
    mem_data = 32'h7777_0011;
    do_read(14'h0011, 32'h7777_0011, 1'b0, "rd_idle_flush_0011");
    mem_data = 32'h7777_0010;
    do_read(14'h0010, 32'h7777_0010, 1'b0, "rd_idle_flush_0010");
  endtask

  task automatic test_reset_fill();
    bit saw_ack;
    mem_hold = 1'b1;
    bus.i_wb_adr = 14'h0012;
    bus.i_wb_we = 1'b0;
    bus.i_wb_sel = 4'hF;
    bus.i_wb_stb = 1'b1;
    repeat (3) @(negedge i_clk);
    checks++;
    if (bus.o_mem_cyc !== 1'b1) begin
      errors++;
      $display("FAIL rst_fill cyc_before got %b want 1", bus.o_mem_cyc);
    end
    i_rst = 1'b1;
    @(negedge i_clk);
    checks++;
    if (bus.o_mem_cyc !== 1'b0 || bus.o_wb_ack !== 1'b0) begin
      errors++;
      $display("FAIL rst_fill after got cyc %b ack %b want 0 0", bus.o_mem_cyc, bus.o_wb_ack);
    end
    i_rst = 1'b0;
    bus.i_wb_stb = 1'b0;
    mem_hold = 1'b0;
    saw_ack = 1'b0;
    repeat (3) begin
      @(negedge i_clk);
      if (bus.o_wb_ack) saw_ack = 1'b1;
    end
    checks++;
    if (saw_ack !== 1'b0) begin
      errors++;
      $display("FAIL rst_fill stray_ack got 1 want 0");
    end
    mem_data = 32'h5555_0011;
    do_read(14'h0011, 32'h5555_0011, 1'b0, "rd_after_rst_0011");
  endtask

  task automatic test_back_to_back();
    logic [31:0] mdl [8];
    logic [ADR_W-1:0] a;
    mem_lat = 2;
    for (int i = 0; i < 8; i++) begin
      a = 14'h0040 + 14'(i);
      mdl[i] = 32'hB0B0_0000 | 32'($urandom_range(0, 65535));
      mem_data = mdl[i];
      do_read(a, mdl[i], 1'b0, "b2b_fill");
    end
    for (int i = 7; i >= 0; i--) begin
      a = 14'h0040 + 14'(i);
      do_read(a, mdl[i], 1'b1, "b2b_hit");
    end
  endtask

  initial begin
    test_reset();
    test_read_miss_hit();
    test_write_merge();
    test_index_wrap();
    test_write_miss();
    test_flush();
    test_reset_fill();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
